// File: rtl/truth_table_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// truth_table_pkg
// Shared types and sizing helpers for the truth-table scanner.
// Revision: 1.0
// ---------------------------------------------------------------------------
package truth_table_pkg;

   // Scanner control states
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int N_IN_DEFAULT = 4;
   localparam int N_VEC        = 2**N_IN_DEFAULT;

   // Number of minterms for an n-input function
   function automatic int vec_count(input int n);
      return 2**n;
   endfunction

   // Settle counter width; a SETTLE of 1 still needs a 1-bit counter
   function automatic int cnt_width(input int settle);
      return (settle > 1) ? $clog2(settle) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_scanner_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// truth_table_scanner_if
// Control, stimulus and result bundle between the scanner and its user.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface truth_table_scanner_if #(
   parameter int N_IN = 4
);
   localparam int N_VEC = 2**N_IN;

   logic              start;
   logic              busy;
   logic              done;
   logic [N_IN-1:0]   drive;
   logic              f_in;
   logic [N_VEC-1:0]  expected;
   // measured minterm mask ("table" is a reserved word)
   logic [N_VEC-1:0]  table_mask;
   logic              mismatch;
   logic [N_IN:0]     err_count;
   logic [N_IN-1:0]   first_bad;

   modport master (
      input  start, f_in, expected,
      output busy, done, drive, table_mask, mismatch, err_count, first_bad
   );

   modport slave (
      output start, f_in, expected,
      input  busy, done, drive, table_mask, mismatch, err_count, first_bad
   );
endinterface
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// truth_table_scanner
// Walks every input combination of an N_IN-input function block, samples
// F after SETTLE cycles per vector, builds the minterm mask and compares it
// with a mask captured at start.
// Revision: 1.0
// ---------------------------------------------------------------------------
module truth_table_scanner
   import truth_table_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   truth_table_scanner_if.master bus
);
   localparam int              NV          = vec_count(N_IN);
   localparam int              CW          = cnt_width(SETTLE);
   localparam logic [N_IN-1:0] LAST_IDX    = N_IN'(NV - 1);
   localparam logic [CW-1:0]   SETTLE_LOAD = CW'(SETTLE - 1);

   state_t            state;
   state_t            state_nxt;
   logic              sample;
   logic              last;

   logic [N_IN-1:0]   drive;
   logic [CW-1:0]     settle_cnt;
   logic [NV-1:0]     exp_q;
   logic [NV-1:0]     tbl;
   logic [N_IN:0]     err_count;
   logic [N_IN-1:0]   first_bad;
   logic              mismatch;
   logic              busy;
   logic              done;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state; a sample happens on the edge that ends the last settle cycle
   always_comb begin
      state_nxt = state;
      sample    = 1'b0;
      last      = (drive == LAST_IDX);
      unique case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN: begin
            sample = (settle_cnt == '0);
            if (sample && last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Vector stepping, sampling and error accumulation
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drive      <= '0;
         settle_cnt <= '0;
         exp_q      <= '0;
         tbl        <= '0;
         err_count  <= '0;
         first_bad  <= '0;
         mismatch   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            // a start in the done cycle is accepted here too
            if (bus.start) begin
               exp_q      <= bus.expected;
               tbl        <= '0;
               err_count  <= '0;
               first_bad  <= '0;
               mismatch   <= 1'b0;
               drive      <= '0;
               settle_cnt <= SETTLE_LOAD;
               busy       <= 1'b1;
            end
         end else if (!sample) begin
            settle_cnt <= settle_cnt - 1'b1;
         end else begin
            tbl[drive] <= bus.f_in;
            if (bus.f_in != exp_q[drive]) begin
               err_count <= err_count + 1'b1;
               mismatch  <= 1'b1;
               // mismatch is still clear only before the first miss of a scan
               if (!mismatch) first_bad <= drive;
            end
            // terminal index ends the scan; drive keeps its last value
            if (last) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               drive      <= drive + 1'b1;
               settle_cnt <= SETTLE_LOAD;
            end
         end
      end
   end

   assign bus.drive      = drive;
   assign bus.table_mask = tbl;
   assign bus.err_count  = err_count;
   assign bus.first_bad  = first_bad;
   assign bus.mismatch   = mismatch;
   assign bus.busy       = busy;
   assign bus.done       = done;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_truth_table_scanner
// Scoreboard bench: two scanners (SETTLE=1 and SETTLE=3) driving the
// exercise function F = A(CD+B)+BC'.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_truth_table_scanner;

   typedef struct {
      logic [15:0] tbl;
      int          errs;
      int          fb;
      logic        mm;
      int          done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   done3_cnt = 0;
   logic mode1 = 1'b0;   // 1: f_in of the SETTLE=1 scanner tied high

   exp_t q1[$];
   exp_t q3[$];

   truth_table_scanner_if #(.N_IN(4)) b1 ();
   truth_table_scanner_if #(.N_IN(4)) b3 ();

   truth_table_scanner #(.N_IN(4), .SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
   truth_table_scanner #(.N_IN(4), .SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

   // Exercise function: drive[3]=A, [2]=B, [1]=C, [0]=D
   function automatic logic fex(input logic [3:0] v);
      logic a, b, c, d;
      {a, b, c, d} = v;
      return (a & ((c & d) | b)) | (b & ~c);
   endfunction

   assign b1.f_in = mode1 ? 1'b1 : fex(b1.drive);
   assign b3.f_in = fex(b3.drive);

   always #5 clk = ~clk;

   // Cycle index = number of rising edges seen
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] mask, input logic tied1, input int dcyc);
      exp_t e;
      e.errs = 0;
      e.fb   = 0;
      for (int i = 0; i < 16; i++) begin
         e.tbl[i] = tied1 ? 1'b1 : fex(4'(i));
         if (e.tbl[i] != mask[i]) begin
            if (e.errs == 0) e.fb = i;
            e.errs++;
         end
      end
      e.mm       = (e.errs != 0);
      e.done_cyc = dcyc;
      return e;
   endfunction

   // Result monitors
   always @(negedge clk) begin
      if (b1.done === 1'b1) begin
         if (q1.size() == 0) chk("d1_spurious_done", 1, 0);
         else begin
            exp_t e;
            e = q1.pop_front();
            chk("d1_done_cyc",   cyc,          e.done_cyc);
            chk("d1_table",      b1.table_mask, e.tbl);
            chk("d1_err_count",  b1.err_count, e.errs);
            chk("d1_first_bad",  b1.first_bad, e.fb);
            chk("d1_mismatch",   b1.mismatch,  e.mm);
            chk("d1_busy_done",  b1.busy,      0);
         end
      end
      if (b3.done === 1'b1) begin
         done3_cnt++;
         if (q3.size() == 0) chk("d3_spurious_done", 1, 0);
         else begin
            exp_t e;
            e = q3.pop_front();
            chk("d3_done_cyc",   cyc,          e.done_cyc);
            chk("d3_table",      b3.table_mask, e.tbl);
            chk("d3_err_count",  b3.err_count, e.errs);
            chk("d3_first_bad",  b3.first_bad, e.fb);
            chk("d3_mismatch",   b3.mismatch,  e.mm);
         end
      end
   end

   task automatic drain1();
      for (int k = 0; k < 400 && q1.size() != 0; k++) @(negedge clk);
      if (q1.size() != 0) begin
         chk("d1_timeout", q1.size(), 0);
         q1.delete();
      end
      @(negedge clk);
   endtask

   task automatic drain3();
      for (int k = 0; k < 400 && q3.size() != 0; k++) @(negedge clk);
      if (q3.size() != 0) begin
         chk("d3_timeout", q3.size(), 0);
         q3.delete();
      end
      @(negedge clk);
   endtask

   task automatic scan1(input logic [15:0] mask, input logic tied1);
      int t0;
      mode1       = tied1;
      b1.expected = mask;
      @(negedge clk);
      b1.start = 1'b1;
      t0 = cyc + 1;
      q1.push_back(model(mask, tied1, t0 + 16));
      @(negedge clk);
      b1.start = 1'b0;
      drain1();
   endtask

   initial begin
      int t0;
      int hold_bad;
      int k;
      b1.start = 1'b0; b1.expected = '0;
      b3.start = 1'b0; b3.expected = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_drive",     b1.drive,      0);
      chk("rst_table",     b1.table_mask, 0);
      chk("rst_err_count", b1.err_count,  0);
      chk("rst_first_bad", b1.first_bad,  0);
      chk("rst_mismatch",  b1.mismatch,   0);
      chk("rst_busy",      b1.busy,       0);
      chk("rst_done",      b1.done,       0);
      rst = 1'b0;
      @(negedge clk);

      // golden pass, single miss, later miss, all miss
      scan1(16'hF830, 1'b0);
      scan1(16'hF831, 1'b0);
      scan1(16'hF830 ^ 16'h0100, 1'b0);
      scan1(16'h0000, 1'b1);
      mode1 = 1'b0;

      // SETTLE=3 hold timing with an ignored start mid-scan
      b3.expected = 16'hF830;
      @(negedge clk);
      b3.start = 1'b1;
      t0 = cyc + 1;
      q3.push_back(model(16'hF830, 1'b0, t0 + 48));
      @(negedge clk);
      b3.start = 1'b0;
      hold_bad = 0;
      for (int j = 0; j < 48; j++) begin
         if (b3.drive !== 4'(j / 3) || b3.busy !== 1'b1) hold_bad++;
         if (j == 10) b3.start = 1'b1;
         if (j == 11) b3.start = 1'b0;
         @(negedge clk);
      end
      chk("s3_hold_errors", hold_bad, 0);
      drain3();
      repeat (20) @(negedge clk);
      chk("s3_done_count", done3_cnt, 1);

      // reset mid-scan
      b1.expected = 16'hF830;
      @(negedge clk);
      b1.start = 1'b1;
      q1.push_back(model(16'hF830, 1'b0, cyc + 17));
      @(negedge clk);
      b1.start = 1'b0;
      k = 0;
      while (b1.drive !== 4'd7 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("rm_reach_7", b1.drive, 7);
      #2 rst = 1'b1;
      q1.delete();
      #1;
      chk("rm_busy",      b1.busy,       0);
      chk("rm_drive",     b1.drive,      0);
      chk("rm_table",     b1.table_mask, 0);
      chk("rm_err_count", b1.err_count,  0);
      chk("rm_mismatch",  b1.mismatch,   0);
      @(negedge clk);
      rst = 1'b0;
      scan1(16'hF830, 1'b0);

      // back-to-back with start held and mask changed mid-scan
      b1.expected = 16'hF830;
      @(negedge clk);
      b1.start = 1'b1;
      t0 = cyc + 1;
      q1.push_back(model(16'hF830, 1'b0, t0 + 16));
      q1.push_back(model(16'hF800, 1'b0, t0 + 17 + 16));
      repeat (5) @(negedge clk);
      b1.expected = 16'hF800;
      while (cyc < t0 + 17) @(negedge clk);
      chk("bb_busy_restart", b1.busy, 1);
      b1.start = 1'b0;
      drain1();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
